// File: rtl/sync_fifo_ctrl.sv
// sync_fifo_ctrl: single-clock FIFO core with the vendor FIFO IP port contract.
// Holds storage, read/write pointers, an occupancy counter, and registered
// full/empty/almost flags. All flags are derived from the next-cycle level,
// so they stay coherent with the water level outputs on every cycle.
// Optional build macro FIFO_ERR_FLAG_EN adds sticky wr_overflow/rd_underflow.
module sync_fifo_ctrl #(
   parameter int unsigned DATA_W    = 8,
   parameter int unsigned ADDR_W    = 8,
   parameter int unsigned AF_THRESH = 252,
   parameter int unsigned AE_THRESH = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_en,
   input  logic [DATA_W-1:0] wr_data,
   output logic              wr_full,
   output logic [ADDR_W:0]   wr_water_level,
   output logic              almost_full,
   input  logic              rd_en,
   output logic [DATA_W-1:0] rd_data,
   output logic              rd_empty,
   output logic [ADDR_W:0]   rd_water_level,
`ifdef FIFO_ERR_FLAG_EN
   output logic              almost_empty,
   output logic              wr_overflow,
   output logic              rd_underflow
`else
   output logic              almost_empty
`endif
);

   localparam int unsigned    DEPTH   = 1 << ADDR_W;
   localparam logic [ADDR_W:0] DEPTH_L = {1'b1, {ADDR_W{1'b0}}};
   localparam logic [ADDR_W:0] AF_L    = AF_THRESH[ADDR_W:0];
   localparam logic [ADDR_W:0] AE_L    = AE_THRESH[ADDR_W:0];

   logic [DATA_W-1:0] mem [DEPTH];
   logic [ADDR_W-1:0] wr_ptr;
   logic [ADDR_W-1:0] rd_ptr;
   logic [ADDR_W:0]   level;
   logic [ADDR_W:0]   level_nxt;
   logic              wr_acc;
   logic              rd_acc;

   // Accept decisions use the registered flags; nothing is accepted in a reset cycle.
   always_comb begin
      wr_acc    = wr_en & ~wr_full  & ~rst;
      rd_acc    = rd_en & ~rd_empty & ~rst;
      level_nxt = level + {{ADDR_W{1'b0}}, wr_acc} - {{ADDR_W{1'b0}}, rd_acc};
   end

   // Storage array: written on accept only, never cleared by reset.
   always_ff @(posedge clk) begin
      if (wr_acc) begin
         mem[wr_ptr] <= wr_data;
      end
   end

   // Pointers, level, read data and flags, all registered from level_nxt.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         level        <= '0;
         rd_data      <= '0;
         wr_full      <= 1'b0;
         rd_empty     <= 1'b1;
         almost_full  <= 1'b0;
         almost_empty <= 1'b1;
      end else begin
         if (wr_acc) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (rd_acc) begin
            rd_data <= mem[rd_ptr];
            rd_ptr  <= rd_ptr + 1'b1;
         end
         level        <= level_nxt;
         wr_full      <= (level_nxt == DEPTH_L);
         rd_empty     <= (level_nxt == '0);
         almost_full  <= (level_nxt >= AF_L);
         almost_empty <= (level_nxt <= AE_L);
      end
   end

   always_comb begin
      wr_water_level = level;
      rd_water_level = level;
   end

`ifdef FIFO_ERR_FLAG_EN
   // Sticky error flags: set by a request against the registered full/empty flag.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_overflow  <= 1'b0;
         rd_underflow <= 1'b0;
      end else begin
         if (wr_en & wr_full) begin
            wr_overflow <= 1'b1;
         end
         if (rd_en & rd_empty) begin
            rd_underflow <= 1'b1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// Testbench for sync_fifo_ctrl: queue-based reference model, per-cycle compare
// process, directed scenarios with literal expectations, then random traffic.
module tb_sync_fifo_ctrl;

   localparam int DEPTH = 256;
   localparam int AF    = 252;
   localparam int AE    = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       wr_en = 1'b0;
   logic [7:0] wr_data = '0;
   logic       rd_en = 1'b0;
   logic       wr_full, almost_full, rd_empty, almost_empty;
   logic [8:0] wr_water_level, rd_water_level;
   logic [7:0] rd_data;
`ifdef FIFO_ERR_FLAG_EN
   logic       wr_overflow, rd_underflow;
`endif

   int total = 0;
   int bad   = 0;

   // reference model state
   logic [7:0] mq[$];
   logic [7:0] m_rd_data = '0;
   bit         m_ovf = 0, m_unf = 0;
   bit         chk_en = 0;

   sync_fifo_ctrl #(.DATA_W(8), .ADDR_W(8), .AF_THRESH(AF), .AE_THRESH(AE)) dut (
      .clk(clk), .rst(rst),
      .wr_en(wr_en), .wr_data(wr_data), .wr_full(wr_full),
      .wr_water_level(wr_water_level), .almost_full(almost_full),
      .rd_en(rd_en), .rd_data(rd_data), .rd_empty(rd_empty),
      .rd_water_level(rd_water_level),
`ifdef FIFO_ERR_FLAG_EN
      .almost_empty(almost_empty), .wr_overflow(wr_overflow), .rd_underflow(rd_underflow)
`else
      .almost_empty(almost_empty)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
      end
   endtask

   // model update: FIFO semantics from occupancy alone
   always @(posedge clk) begin
      if (rst) begin
         mq.delete();
         m_rd_data = '0;
         m_ovf = 0;
         m_unf = 0;
      end else begin
         bit full_now, empty_now;
         full_now  = (mq.size() == DEPTH);
         empty_now = (mq.size() == 0);
         if (wr_en && full_now)  m_ovf = 1;
         if (rd_en && empty_now) m_unf = 1;
         if (rd_en && !empty_now) m_rd_data = mq.pop_front();
         if (wr_en && !full_now)  mq.push_back(wr_data);
      end
   end

   // per-cycle compare on the falling edge
   always @(negedge clk) begin
      if (chk_en) begin
         int n;
         n = mq.size();
         chk("wr_water_level", 32'(wr_water_level), 32'(n));
         chk("rd_water_level", 32'(rd_water_level), 32'(n));
         chk("wr_full",        32'(wr_full),        32'(n == DEPTH));
         chk("rd_empty",       32'(rd_empty),       32'(n == 0));
         chk("almost_full",    32'(almost_full),    32'(n >= AF));
         chk("almost_empty",   32'(almost_empty),   32'(n <= AE));
         chk("rd_data",        32'(rd_data),        32'(m_rd_data));
`ifdef FIFO_ERR_FLAG_EN
         chk("wr_overflow",    32'(wr_overflow),    32'(m_ovf));
         chk("rd_underflow",   32'(rd_underflow),   32'(m_unf));
`endif
      end
   end

   // drive one cycle; returns #1 after the active edge so outputs are settled
   task automatic step(input bit w, input logic [7:0] d, input bit r);
      @(negedge clk);
      wr_en   = w;
      wr_data = d;
      rd_en   = r;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      wr_en = 1'b0;
      rd_en = 1'b0;
      @(posedge clk);
      #1;
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      logic [7:0] exp_head;
      logic [7:0] prev_rd;

      // reset and idle
      do_reset();
      chk_en = 1;
      step(0, 8'h00, 0);
      chk("rst_empty",  32'(rd_empty), 32'd1);
      chk("rst_full",   32'(wr_full), 32'd0);
      chk("rst_ae",     32'(almost_empty), 32'd1);
      chk("rst_af",     32'(almost_full), 32'd0);
      chk("rst_wlvl",   32'(wr_water_level), 32'd0);
      chk("rst_rlvl",   32'(rd_water_level), 32'd0);
      chk("rst_rdata",  32'(rd_data), 32'd0);

      // fill 0x00..0xFF
      for (int i = 0; i < 256; i++) begin
         step(1, 8'(i), 0);
         if (i == 3)   chk("ae_at4",   32'(almost_empty), 32'd1);
         if (i == 4) begin
            chk("ae_at5",  32'(almost_empty), 32'd0);
            chk("lvl_5",   32'(wr_water_level), 32'd5);
         end
         if (i == 250) chk("af_at251", 32'(almost_full), 32'd0);
         if (i == 251) chk("af_at252", 32'(almost_full), 32'd1);
      end
      chk("full_256", 32'(wr_full), 32'd1);
      chk("lvl_256",  32'(wr_water_level), 32'd256);
      step(1, 8'hAA, 0);
      chk("ovf_lvl",  32'(wr_water_level), 32'd256);
      chk("ovf_full", 32'(wr_full), 32'd1);

      // drain, data 0x00..0xFF one cycle after each rd_en
      for (int i = 0; i < 256; i++) begin
         step(0, 8'h00, 1);
         chk("drain_data", 32'(rd_data), 32'(i));
      end
      chk("drain_empty", 32'(rd_empty), 32'd1);
      step(0, 8'h00, 1);
      chk("unf_rdata", 32'(rd_data), 32'hFF);
      chk("unf_lvl",   32'(rd_water_level), 32'd0);

      // preload 100, then 300 cycles of simultaneous write+read across wrap
      for (int i = 0; i < 100; i++) step(1, 8'($urandom), 0);
      for (int i = 0; i < 300; i++) step(1, 8'($urandom), 1);
      chk("wrap_lvl", 32'(wr_water_level), 32'd100);

      // full with both requests: read wins, write dropped
      for (int i = 0; i < 156; i++) step(1, 8'($urandom), 0);
      chk("refill_full", 32'(wr_full), 32'd1);
      exp_head = mq[0];
      step(1, 8'h5A, 1);
      chk("fb_lvl",   32'(wr_water_level), 32'd255);
      chk("fb_full",  32'(wr_full), 32'd0);
      chk("fb_rdata", 32'(rd_data), 32'(exp_head));

      // empty with both requests: write wins, rd_data holds
      while (mq.size() > 0) step(0, 8'h00, 1);
      prev_rd = rd_data;
      step(1, 8'h33, 1);
      chk("eb_lvl",   32'(wr_water_level), 32'd1);
      chk("eb_rdata", 32'(rd_data), 32'(prev_rd));
      step(0, 8'h00, 1);
      chk("eb_read",  32'(rd_data), 32'h33);

      // reset with 50 entries and requests high during reset
      for (int i = 0; i < 50; i++) step(1, 8'($urandom), 0);
      step(1, 8'hEE, 1);
      step(1, 8'h00, 0);
      @(negedge clk);
      rst = 1'b1; wr_en = 1'b1; rd_en = 1'b1; wr_data = 8'h77;
      @(posedge clk);
      #1;
      chk("mid_rst_lvl",   32'(wr_water_level), 32'd0);
      chk("mid_rst_empty", 32'(rd_empty), 32'd1);
`ifdef FIFO_ERR_FLAG_EN
      chk("mid_rst_ovf",   32'(wr_overflow), 32'd0);
      chk("mid_rst_unf",   32'(rd_underflow), 32'd0);
`endif
      @(negedge clk);
      rst = 1'b0; wr_en = 1'b0; rd_en = 1'b0;

      // random traffic with shifting write/read bias
      for (int seg = 0; seg < 8; seg++) begin
         int wp, rp;
         wp = (seg % 2 == 0) ? 85 : 20;
         rp = (seg % 2 == 0) ? 20 : 85;
         for (int i = 0; i < 400; i++) begin
            if ($urandom_range(999) == 0) begin
               @(negedge clk);
               rst = 1'b1;
               wr_en = ($urandom_range(1) == 1);
               rd_en = ($urandom_range(1) == 1);
               @(posedge clk);
               #1;
               @(negedge clk);
               rst = 1'b0;
            end else begin
               step($urandom_range(99) < wp, 8'($urandom), $urandom_range(99) < rp);
            end
         end
      end
      step(0, 8'h00, 0);
      step(0, 8'h00, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
